// File: rtl/softmax_mem_ctrl_pkg.sv
// softmax_mem_ctrl_pkg: shared FSM state encoding and error codes for the softmax memory controller
package softmax_mem_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_START,
        S_RUN,
        S_FIN,
        S_ERR
    } state_e;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;
endpackage

// File: rtl/sm_rd_bank.sv
// sm_rd_bank: 1-write/1-read synchronous RAM with registered, read-before-write output
module sm_rd_bank #(
    parameter int DW = 64,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
    always_ff @(posedge clk) rdata_q <= reset ? '0 : mem[raddr_i];
    assign rdata_o = rdata_q;
endmodule

// File: rtl/softmax_mem_ctrl.sv
// softmax_mem_ctrl: command FSM, replicated input memory and result memory around a softmax engine
module softmax_mem_ctrl
    import softmax_mem_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int ADDRSIZE  = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRSIZE-1:0]       cmd_start_addr,
    input  logic [ADDRSIZE-1:0]       cmd_end_addr,
    input  logic                      ld_en,
    input  logic [ADDRSIZE-1:0]       ld_addr,
    input  logic [DATAWIDTH*NUM-1:0]  ld_data,
    output logic                      sm_init,
    output logic                      sm_start,
    output logic [ADDRSIZE-1:0]       sm_start_addr,
    output logic [ADDRSIZE-1:0]       sm_end_addr,
    input  logic [ADDRSIZE-1:0]       sm_addr,
    input  logic [ADDRSIZE-1:0]       sm_sub0_addr,
    input  logic [ADDRSIZE-1:0]       sm_sub1_addr,
    output logic [DATAWIDTH*NUM-1:0]  sm_inp,
    output logic [DATAWIDTH*NUM-1:0]  sm_sub0_inp,
    output logic [DATAWIDTH*NUM-1:0]  sm_sub1_inp,
    input  logic [DATAWIDTH*NUM-1:0]  sm_outp,
    input  logic                      sm_outp_valid,
    input  logic                      sm_done,
    input  logic [ADDRSIZE-1:0]       res_rd_addr,
    output logic [DATAWIDTH*NUM-1:0]  res_rd_data,
    output logic                      busy,
    output logic                      done_pulse,
    output logic                      err,
    output logic [1:0]                err_code
);
    localparam int W   = DATAWIDTH * NUM;
    localparam int WDW = $clog2(TIMEOUT + 1);
    state_e              state_q, state_d;
    logic [ADDRSIZE-1:0] start_q, start_d, end_q, end_d;
    logic [ADDRSIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                in_range, res_we, ld_we;
    // wr_ptr carries an extra bit so a range ending at the top address cannot wrap back into range
    assign in_range = wr_ptr_q <= {1'b0, end_q};
    assign ld_we    = ld_en && !busy;
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        wr_ptr_d   = wr_ptr_q;
        wd_d       = wd_q;
        err_code_d = err_code_q;
        res_we     = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                if (cmd_end_addr >= cmd_start_addr) begin
                    state_d    = S_INIT;
                    start_d    = cmd_start_addr;
                    end_d      = cmd_end_addr;
                    wr_ptr_d   = {1'b0, cmd_start_addr};
                    err_code_d = ERR_NONE;
                end else if (err_code_q == ERR_NONE) begin
                    err_code_d = ERR_RANGE;
                end
            end
            S_INIT:  state_d = S_START;
            S_START: begin
                state_d = S_RUN;
                wd_d    = '0;
            end
            S_RUN: begin
                if (sm_outp_valid) begin
                    if (in_range) begin
                        res_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else if (err_code_q == ERR_NONE) begin
                        err_code_d = ERR_OVF;
                    end
                end
                if (sm_done) begin
                    state_d = S_FIN;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d    = S_ERR;
                    err_code_d = (err_code_d == ERR_NONE) ? ERR_TIMEOUT : err_code_d;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            end_q      <= '0;
            wr_ptr_q   <= '0;
            wd_q       <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            end_q      <= end_d;
            wr_ptr_q   <= wr_ptr_d;
            wd_q       <= wd_d;
            err_code_q <= err_code_d;
        end
    end
    assign cmd_ready     = state_q == S_IDLE;
    assign sm_init       = state_q == S_INIT;
    assign sm_start      = state_q == S_START;
    assign done_pulse    = state_q == S_FIN;
    assign busy          = state_q inside {S_INIT, S_START, S_RUN, S_FIN};
    assign sm_start_addr = start_q;
    assign sm_end_addr   = end_q;
    assign err           = err_code_q != ERR_NONE;
    assign err_code      = err_code_q;
    sm_rd_bank #(.DW(W), .AW(ADDRSIZE)) u_in0 (
        .clk(clk), .reset(reset), .we_i(ld_we), .waddr_i(ld_addr), .wdata_i(ld_data),
        .raddr_i(sm_addr), .rdata_o(sm_inp)
    );
    sm_rd_bank #(.DW(W), .AW(ADDRSIZE)) u_in1 (
        .clk(clk), .reset(reset), .we_i(ld_we), .waddr_i(ld_addr), .wdata_i(ld_data),
        .raddr_i(sm_sub0_addr), .rdata_o(sm_sub0_inp)
    );
    sm_rd_bank #(.DW(W), .AW(ADDRSIZE)) u_in2 (
        .clk(clk), .reset(reset), .we_i(ld_we), .waddr_i(ld_addr), .wdata_i(ld_data),
        .raddr_i(sm_sub1_addr), .rdata_o(sm_sub1_inp)
    );
    sm_rd_bank #(.DW(W), .AW(ADDRSIZE)) u_res (
        .clk(clk), .reset(reset), .we_i(res_we), .waddr_i(wr_ptr_q[ADDRSIZE-1:0]), .wdata_i(sm_outp),
        .raddr_i(res_rd_addr), .rdata_o(res_rd_data)
    );
endmodule

// File: tb/tb_softmax_mem_ctrl.sv
// tb_softmax_mem_ctrl: directed scoreboard bench for softmax_mem_ctrl
module tb_softmax_mem_ctrl;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int W  = DW * N;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_start_addr = '0, cmd_end_addr = '0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic          sm_init, sm_start;
    logic [AW-1:0] sm_start_addr, sm_end_addr;
    logic [AW-1:0] sm_addr = '0, sm_sub0_addr = '0, sm_sub1_addr = '0;
    logic [W-1:0]  sm_inp, sm_sub0_inp, sm_sub1_inp;
    logic [W-1:0]  sm_outp = '0;
    logic          sm_outp_valid = 1'b0, sm_done = 1'b0;
    logic [AW-1:0] res_rd_addr = '0;
    logic [W-1:0]  res_rd_data;
    logic          busy, done_pulse, err;
    logic [1:0]    err_code;
    int            compared = 0;
    int            mismatched = 0;
    logic [W-1:0]  sb[$];

    softmax_mem_ctrl #(.DATAWIDTH(DW), .NUM(N), .ADDRSIZE(AW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .sm_init(sm_init), .sm_start(sm_start),
        .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
        .sm_addr(sm_addr), .sm_sub0_addr(sm_sub0_addr), .sm_sub1_addr(sm_sub1_addr),
        .sm_inp(sm_inp), .sm_sub0_inp(sm_sub0_inp), .sm_sub1_inp(sm_sub1_inp),
        .sm_outp(sm_outp), .sm_outp_valid(sm_outp_valid), .sm_done(sm_done),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
        .busy(busy), .done_pulse(done_pulse), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] wd(input int k);
        logic [DW-1:0] lane;
        lane = DW'(k);
        return {N{lane}};
    endfunction
    function automatic logic [W-1:0] rv(input int k);
        return 64'hC0DE_0000_0000_0000 | W'(k);
    endfunction
    function automatic logic [W-1:0] sv(input int k);
        return 64'h5EC0_0000_0000_0000 | W'(k);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic pop(input string tag, input logic [W-1:0] obs);
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            chk(tag, obs, sb.pop_front());
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cmd(input int s, input int e);
        cmd_valid = 1'b1;
        cmd_start_addr = AW'(s);
        cmd_end_addr = AW'(e);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cmd_ready", W'(cmd_ready), 1);
        chk("rst_busy", W'(busy), 0);
        chk("rst_err", W'({err, err_code}), 0);
        chk("rst_ctrl", W'({sm_init, sm_start, done_pulse}), 0);
        chk("rst_addrs", W'({sm_start_addr, sm_end_addr}), 0);
        chk("rst_rdata", sm_inp | sm_sub0_inp | sm_sub1_inp | res_rd_data, 0);
        for (int k = 0; k < 8; k++) begin
            ld_en = 1'b1;
            ld_addr = AW'(k);
            ld_data = wd(k);
            tick();
        end
        ld_addr = 8'd8;
        ld_data = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        ld_data = 64'hBBBB_BBBB_BBBB_BBBB;
        sm_addr = 8'd8;
        sb.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        pop("rbw_old", sm_inp);
        ld_en = 1'b0;
        sb.push_back(64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        pop("rbw_new", sm_inp);
        sm_addr = 8'd3;
        sm_sub0_addr = 8'd5;
        sm_sub1_addr = 8'd7;
        sb.push_back(wd(3));
        sb.push_back(wd(5));
        sb.push_back(wd(7));
        tick();
        pop("rd_inp", sm_inp);
        pop("rd_sub0", sm_sub0_inp);
        pop("rd_sub1", sm_sub1_inp);

        cmd(2, 5);
        chk("init_pulse", W'({sm_init, sm_start, busy, cmd_ready}), W'(4'b1010));
        chk("init_addrs", W'({sm_start_addr, sm_end_addr}), W'({8'd2, 8'd5}));
        ld_en = 1'b1;
        ld_addr = 8'd0;
        ld_data = '1;
        tick();
        ld_en = 1'b0;
        chk("start_pulse", W'({sm_init, sm_start, err}), W'(3'b010));
        tick();
        for (int i = 0; i < 4; i++) begin
            sm_outp_valid = 1'b1;
            sm_outp = rv(i);
            if (i == 0) begin
                sm_addr = 8'd3;
                sb.push_back(wd(3));
            end
            tick();
            if (i == 0) pop("run_rd", sm_inp);
        end
        sm_outp_valid = 1'b0;
        sm_done = 1'b1;
        tick();
        sm_done = 1'b0;
        chk("fin_done", W'({done_pulse, busy}), W'(2'b11));
        tick();
        chk("idle_after", W'({done_pulse, busy, cmd_ready, err}), W'(4'b0010));
        for (int a = 2; a <= 5; a++) begin
            res_rd_addr = AW'(a);
            sb.push_back(rv(a - 2));
            tick();
            pop("res_word", res_rd_data);
        end
        sm_addr = 8'd0;
        sb.push_back(wd(0));
        tick();
        pop("ld_busy_ignored", sm_inp);

        cmd(6, 1);
        chk("bad_range", W'({err, err_code, sm_init, cmd_ready, busy}), W'(6'b101_0_1_0));
        tick();
        chk("bad_range_no_init", W'({sm_init, err_code}), W'(3'b001));

        cmd(2, 5);
        chk("err_cleared", W'({err, err_code}), 0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            sm_outp_valid = 1'b1;
            sm_outp = sv(i);
            if (i == 0) begin
                res_rd_addr = 8'd2;
                sb.push_back(rv(0));
            end
            tick();
            if (i == 0) pop("res_rbw_old", res_rd_data);
            if (i == 3) chk("ovf_not_yet", W'(err_code), 0);
        end
        sm_outp_valid = 1'b0;
        chk("ovf_code", W'({err, err_code, busy}), W'(4'b1111));
        sm_done = 1'b1;
        tick();
        sm_done = 1'b0;
        chk("ovf_fin", W'(done_pulse), 1);
        tick();
        for (int a = 2; a <= 5; a++) begin
            res_rd_addr = AW'(a);
            sb.push_back(sv(a - 2));
            tick();
            pop("ovf_res_word", res_rd_data);
        end

        cmd(0, 3);
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("wd_cycle15", W'({busy, err_code}), W'(3'b100));
        tick();
        chk("wd_timeout", W'({busy, cmd_ready, err, err_code, done_pulse}), W'(6'b00_1_10_0));
        tick();
        chk("wd_idle", W'({cmd_ready, err_code}), W'(3'b110));

        cmd(0, 3);
        tick();
        tick();
        sm_outp_valid = 1'b1;
        sm_outp = rv(9);
        tick();
        sm_outp_valid = 1'b0;
        reset = 1'b1;
        sm_done = 1'b1;
        tick();
        chk("mid_rst_ctrl", W'({cmd_ready, busy, done_pulse, sm_init, sm_start, err, err_code}), W'(8'b1000_0000));
        chk("mid_rst_addrs", W'({sm_start_addr, sm_end_addr}), 0);
        chk("mid_rst_rdata", sm_inp | res_rd_data, 0);
        reset = 1'b0;
        sm_done = 1'b0;
        tick();
        chk("mid_rst_no_done", W'({done_pulse, cmd_ready}), W'(2'b01));
        sm_addr = 8'd3;
        res_rd_addr = 8'd0;
        sb.push_back(wd(3));
        sb.push_back(rv(9));
        tick();
        pop("mem_kept_in", sm_inp);
        pop("mem_kept_res", res_rd_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
